// File: rtl/vx_bitmanip_seq.sv
// ============================================================================
// vx_bitmanip_seq
// ----------------------------------------------------------------------------
// Issue sequencer that lets NUM_REQS requesters share one bitmanip datapath.
// One op is in flight at a time: IDLE picks a winner (round-robin), EXEC runs
// the datapath for 1 cycle (single) or MULTI_LAT cycles (iterative), RESP
// holds the result until the commit stage accepts it.
//
// Ports
//   clk          : clock, all state on the rising edge
//   reset_n      : asynchronous, active-low reset
//   req_valid    : [NUM_REQS]        per-requester request valid
//   req_op       : [NUM_REQS*OPW]    per-requester op_type
//   req_multi    : [NUM_REQS]        per-requester "op is iterative" flag
//   req_tag      : [NUM_REQS*TAG_W]  per-requester opaque tag
//   req_ready    : [NUM_REQS]        per-requester accept (combinational)
//   exe_grant    : [NUM_REQS]        one-hot operand-mux select, zero outside EXEC
//   exe_op       : [OPW]             latched op, zero outside EXEC
//   exe_start    : one-cycle start pulse on the first EXEC cycle
//   exe_busy     : datapath executing
//   rsp_valid    : result ready for commit
//   rsp_ready    : commit accepts
//   rsp_tag      : [TAG_W]           tag of the completing op
//   rsp_src      : [SRC_W]           index of the originating requester
//   busy_cycles  : [32]              wrapping count of exe_busy cycles
// ============================================================================
module vx_bitmanip_seq #(
    parameter int          NUM_REQS    = 2,
    parameter int          OPW         = 4,
    parameter int          TAG_W       = 64,
    parameter int          MULTI_LAT   = 8,
    // Reset value of busy_cycles; leave at 0 for normal use.
    parameter logic [31:0] BUSY_PRESET = 32'd0,
    localparam int         SRC_W       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*OPW-1:0]   req_op,
    input  logic [NUM_REQS-1:0]       req_multi,
    input  logic [NUM_REQS*TAG_W-1:0] req_tag,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic [NUM_REQS-1:0]       exe_grant,
    output logic [OPW-1:0]            exe_op,
    output logic                      exe_start,
    output logic                      exe_busy,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic [SRC_W-1:0]          rsp_src,
    output logic [31:0]               busy_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [7:0]         cnt_reg;
    logic [SRC_W-1:0]   last_reg;
    logic [SRC_W-1:0]   src_reg;
    logic [OPW-1:0]     op_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               first_reg;
    logic               armed_reg;
    logic [31:0]        busy_reg;

    // Per-requester views of the packed request buses.
    logic [OPW-1:0]     op_arr  [NUM_REQS];
    logic [TAG_W-1:0]   tag_arr [NUM_REQS];

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
            assign op_arr[gi]  = req_op[gi*OPW +: OPW];
            assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: scan starting one past the last accepted requester.
    // ------------------------------------------------------------------
    logic             found;
    logic [SRC_W-1:0] win_idx;
    int               scan_idx;

    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            scan_idx = (int'(last_reg) + 1 + i) % NUM_REQS;
            if (!found && req_valid[SRC_W'(scan_idx)]) begin
                found   = 1'b1;
                win_idx = SRC_W'(scan_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / accept logic.
    // armed_reg keeps req_ready low until the first clock edge after reset
    // release, so nothing is accepted in the partial cycle following it.
    // ------------------------------------------------------------------
    logic accept;

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (found && armed_reg) begin
                    req_ready[win_idx] = 1'b1;
                    accept             = 1'b1;
                    state_next         = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_reg == 8'd0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and latches.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 8'd0;
            last_reg  <= SRC_W'(NUM_REQS - 1);
            src_reg   <= '0;
            op_reg    <= '0;
            tag_reg   <= '0;
            first_reg <= 1'b0;
            armed_reg <= 1'b0;
            busy_reg  <= BUSY_PRESET;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
            first_reg <= accept;
            if (accept) begin
                op_reg   <= op_arr[win_idx];
                tag_reg  <= tag_arr[win_idx];
                src_reg  <= win_idx;
                last_reg <= win_idx;
                // Counter holds the number of EXEC cycles still to follow.
                cnt_reg  <= req_multi[win_idx] ? 8'(MULTI_LAT - 1) : 8'd0;
            end else if (state_reg == S_EXEC && cnt_reg != 8'd0) begin
                cnt_reg <= cnt_reg - 8'd1;
            end
            if (state_reg == S_EXEC) begin
                busy_reg <= busy_reg + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: datapath and response fields are gated to zero outside the
    // state in which they are meaningful.
    // ------------------------------------------------------------------
    assign exe_busy    = (state_reg == S_EXEC);
    assign exe_start   = exe_busy && first_reg;
    assign exe_op      = exe_busy ? op_reg : '0;
    assign rsp_valid   = (state_reg == S_RESP);
    assign rsp_tag     = rsp_valid ? tag_reg : '0;
    assign rsp_src     = rsp_valid ? src_reg : '0;
    assign busy_cycles = busy_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_grant
            assign exe_grant[gi] = exe_busy && (src_reg == SRC_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_vx_bitmanip_seq.sv
// ============================================================================
// tb_vx_bitmanip_seq
// Self-checking bench for vx_bitmanip_seq. A timeline model (accept cycle,
// latency, handshake) predicts every output each cycle; directed sections pin
// the model with hand-computed literals, then a randomized section runs.
// A second instance with a busy_cycles preset near 2^32 exercises the wrap.
// ============================================================================
module tb_vx_bitmanip_seq;

    localparam int          NUM_REQS  = 2;
    localparam int          OPW       = 4;
    localparam int          TAG_W     = 64;
    localparam int          MULTI_LAT = 8;
    localparam int          SRC_W     = 1;
    localparam logic [31:0] PRESET_W  = 32'hFFFF_FFFA;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS*OPW-1:0]   req_op;
    logic [NUM_REQS-1:0]       req_multi;
    logic [NUM_REQS*TAG_W-1:0] req_tag;
    logic [NUM_REQS-1:0]       req_ready;
    logic [NUM_REQS-1:0]       exe_grant;
    logic [OPW-1:0]            exe_op;
    logic                      exe_start;
    logic                      exe_busy;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [TAG_W-1:0]          rsp_tag;
    logic [SRC_W-1:0]          rsp_src;
    logic [31:0]               busy_cycles;

    // Outputs of the wrap instance; only busy_cycles_w is checked.
    logic [NUM_REQS-1:0]       req_ready_w;
    logic [NUM_REQS-1:0]       exe_grant_w;
    logic [OPW-1:0]            exe_op_w;
    logic                      exe_start_w;
    logic                      exe_busy_w;
    logic                      rsp_valid_w;
    logic [TAG_W-1:0]          rsp_tag_w;
    logic [SRC_W-1:0]          rsp_src_w;
    logic [31:0]               busy_cycles_w;

    vx_bitmanip_seq #(
        .NUM_REQS(NUM_REQS), .OPW(OPW), .TAG_W(TAG_W), .MULTI_LAT(MULTI_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_op(req_op), .req_multi(req_multi), .req_tag(req_tag),
        .req_ready(req_ready), .exe_grant(exe_grant), .exe_op(exe_op),
        .exe_start(exe_start), .exe_busy(exe_busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_src(rsp_src),
        .busy_cycles(busy_cycles)
    );

    vx_bitmanip_seq #(
        .NUM_REQS(NUM_REQS), .OPW(OPW), .TAG_W(TAG_W), .MULTI_LAT(MULTI_LAT),
        .BUSY_PRESET(PRESET_W)
    ) dut_w (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_op(req_op), .req_multi(req_multi), .req_tag(req_tag),
        .req_ready(req_ready_w), .exe_grant(exe_grant_w), .exe_op(exe_op_w),
        .exe_start(exe_start_w), .exe_busy(exe_busy_w),
        .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag_w), .rsp_src(rsp_src_w),
        .busy_cycles(busy_cycles_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model: an accepted op at cycle t with latency L occupies the
    // datapath on cycles t+1..t+L and offers its response from t+L+1 until
    // the cycle rsp_ready is seen.
    // ------------------------------------------------------------------
    bit               m_armed    = 0;
    bit               m_inflight = 0;
    int               m_acc      = 0;
    int               m_lat      = 1;
    int               m_src      = 0;
    int               m_last     = NUM_REQS - 1;
    logic [OPW-1:0]   m_op       = '0;
    logic [TAG_W-1:0] m_tag      = '0;
    logic [31:0]      m_busy     = 32'd0;
    logic [31:0]      m_busy_w   = PRESET_W;

    logic [NUM_REQS-1:0] e_ready, e_grant;
    logic                e_busy, e_start, e_rvalid;
    int                  e_win;

    always @(negedge clk) begin
        #2;
        if (!reset_n) begin
            m_inflight = 0;
            m_armed    = 0;
            m_last     = NUM_REQS - 1;
            m_busy     = 32'd0;
            m_busy_w   = PRESET_W;
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_exe_grant", 64'(exe_grant), 64'd0);
            chk("rst_exe_op",    64'(exe_op),    64'd0);
            chk("rst_exe_start", 64'(exe_start), 64'd0);
            chk("rst_exe_busy",  64'(exe_busy),  64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_tag",   rsp_tag,        64'd0);
            chk("rst_rsp_src",   64'(rsp_src),   64'd0);
            chk("rst_busy_cyc",  64'(busy_cycles),   64'd0);
            chk("rst_busy_cyc_w", 64'(busy_cycles_w), 64'(PRESET_W));
        end else begin
            e_ready = '0;
            e_win   = -1;
            if (m_armed && !m_inflight) begin
                for (int k = 0; k < NUM_REQS; k++) begin
                    int c;
                    c = (m_last + 1 + k) % NUM_REQS;
                    if (e_win < 0 && req_valid[c]) e_win = c;
                end
                if (e_win >= 0) e_ready[e_win] = 1'b1;
            end
            e_busy   = m_inflight && (cyc >= m_acc + 1) && (cyc <= m_acc + m_lat);
            e_start  = m_inflight && (cyc == m_acc + 1);
            e_rvalid = m_inflight && (cyc > m_acc + m_lat);
            e_grant  = '0;
            if (e_busy) e_grant[m_src] = 1'b1;

            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("exe_grant", 64'(exe_grant), 64'(e_grant));
            chk("exe_op",    64'(exe_op),    e_busy ? 64'(m_op) : 64'd0);
            chk("exe_start", 64'(exe_start), 64'(e_start));
            chk("exe_busy",  64'(exe_busy),  64'(e_busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rvalid));
            chk("rsp_tag",   rsp_tag,        e_rvalid ? m_tag : 64'd0);
            chk("rsp_src",   64'(rsp_src),   e_rvalid ? 64'(m_src) : 64'd0);
            chk("busy_cycles",   64'(busy_cycles),   64'(m_busy));
            chk("busy_cycles_w", 64'(busy_cycles_w), 64'(m_busy_w));

            if (e_busy) begin
                m_busy   = m_busy + 32'd1;
                m_busy_w = m_busy_w + 32'd1;
            end
            if (e_win >= 0) begin
                m_inflight = 1;
                m_acc      = cyc;
                m_src      = e_win;
                m_last     = e_win;
                m_lat      = req_multi[e_win] ? MULTI_LAT : 1;
                m_op       = req_op[e_win*OPW +: OPW];
                m_tag      = req_tag[e_win*TAG_W +: TAG_W];
                $display("TXN accept cyc=%0d src=%0d op=%h lat=%0d tag=%h",
                         cyc, e_win, m_op, m_lat, m_tag);
            end else if (e_rvalid && rsp_ready) begin
                m_inflight = 0;
                $display("TXN commit cyc=%0d src=%0d tag=%h", cyc, m_src, m_tag);
            end
            m_armed = 1;
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus with hand-computed literal expectations.
    // ------------------------------------------------------------------
    task automatic set_req(input int i, input logic [OPW-1:0] op, input logic m,
                           input logic [TAG_W-1:0] tag);
        req_valid[i]                = 1'b1;
        req_multi[i]                = m;
        req_op[i*OPW +: OPW]        = op;
        req_tag[i*TAG_W +: TAG_W]   = tag;
    endtask

    int                  g_idx [4];
    int                  ng;
    logic [NUM_REQS-1:0] last_ready;

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_multi = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("lit_reset_busy", 64'(busy_cycles), 64'd0);
        chk("lit_reset_rvalid", 64'(rsp_valid), 64'd0);

        // Release reset with a request already pending: not accepted yet.
        @(negedge clk);
        reset_n = 1'b1;
        set_req(0, 4'h3, 1'b0, 64'hA5);
        #3 chk("lit_prearm_ready", 64'(req_ready), 64'd0);

        // Single op: accept at 0, start at 1, response at 2.
        @(negedge clk);
        #3 chk("lit_single_ready", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = '0;
        #3;
        chk("lit_single_start", 64'(exe_start), 64'd1);
        chk("lit_single_grant", 64'(exe_grant), 64'b01);
        chk("lit_single_op",    64'(exe_op),    64'h3);
        @(negedge clk);
        #3;
        chk("lit_single_rvalid", 64'(rsp_valid), 64'd1);
        chk("lit_single_tag",    rsp_tag,        64'hA5);
        chk("lit_single_src",    64'(rsp_src),   64'd0);
        chk("lit_single_busy",   64'(busy_cycles), 64'd1);
        @(negedge clk);

        // Multi op from requester 1: busy on cycles 1..8, response at 9.
        @(negedge clk);
        set_req(1, 4'h9, 1'b1, 64'h1234_5678_9ABC_DEF0);
        #3 chk("lit_multi_ready", 64'(req_ready), 64'b10);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            req_valid = '0;
            #3;
            chk("lit_multi_busy",   64'(exe_busy),  64'(c <= 8));
            chk("lit_multi_start",  64'(exe_start), 64'(c == 1));
            chk("lit_multi_rvalid", 64'(rsp_valid), 64'(c == 9));
            if (c == 1) chk("lit_multi_grant", 64'(exe_grant), 64'b10);
        end
        chk("lit_multi_tag",    rsp_tag,              64'h1234_5678_9ABC_DEF0);
        chk("lit_multi_src",    64'(rsp_src),         64'd1);
        chk("lit_multi_bcyc",   64'(busy_cycles),     64'd9);
        chk("lit_multi_bcyc_w", 64'(busy_cycles_w),   64'd3);
        req_multi = '0;
        @(negedge clk);

        // Contention: both valid for 12 cycles -> grants 0,1,0,1.
        @(negedge clk);
        set_req(0, 4'h1, 1'b0, 64'h100);
        set_req(1, 4'h2, 1'b0, 64'h200);
        ng = 0;
        for (int k = 0; k < 12; k++) begin
            #3;
            for (int i = 0; i < NUM_REQS; i++)
                if (req_ready[i] && ng < 4) begin
                    g_idx[ng] = i;
                    ng++;
                end
            @(negedge clk);
        end
        req_valid = '0;
        chk("lit_cont_count", 64'(ng), 64'd4);
        for (int k = 0; k < 4; k++)
            if (k < ng) chk("lit_cont_grant", 64'(g_idx[k]), 64'(k % 2));
        repeat (3) @(negedge clk);

        // Backpressure: rsp_ready low for 5 RESP cycles.
        set_req(0, 4'h5, 1'b0, 64'hBEEF);
        #3 chk("lit_bp_ready0", 64'(req_ready), 64'b01);
        @(negedge clk);
        set_req(1, 4'h6, 1'b0, 64'hCAFE);
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            chk("lit_bp_rvalid", 64'(rsp_valid), 64'd1);
            chk("lit_bp_tag",    rsp_tag,        64'hBEEF);
            chk("lit_bp_ready",  64'(req_ready), 64'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #3 chk("lit_bp_release_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        #3 chk("lit_bp_next_ready", 64'(req_ready), 64'b10);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);

        // Reset during EXEC cycle 4 of a multi op from requester 0.
        set_req(0, 4'hC, 1'b1, 64'h39);
        #3 chk("lit_rst_accept", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = '0;
        req_multi = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #3;
        chk("lit_rst_busy",  64'(exe_busy),    64'd0);
        chk("lit_rst_grant", 64'(exe_grant),   64'd0);
        chk("lit_rst_bcyc",  64'(busy_cycles), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        set_req(0, 4'h1, 1'b0, 64'h51);
        set_req(1, 4'h2, 1'b0, 64'h52);
        #3 chk("lit_rst_prearm", 64'(req_ready), 64'd0);
        @(negedge clk);
        #3 chk("lit_rst_first_grant", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = '0;
        repeat (12) @(negedge clk);

        // Randomized traffic: requesters hold valid until accepted.
        last_ready = '0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 249) == 0) reset_n = 1'b0;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (req_valid[i] && last_ready[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, OPW'($urandom), ($urandom_range(0, 3) == 0),
                            {$urandom, $urandom});
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #3 last_ready = req_ready;
        end
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (15) @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
